// File: rtl/inv_converter_pipe.sv
// Two-stage per-lane sign conversion (pass / negate / abs / conditional negate) at DATA_W+1 bits.
// Latency: 2 cycles from input acceptance to out_valid. Throughput: 1 beat per cycle.
// Backpressure: stalled stages hold their contents; in_ready = ~v1 | ~v2 | out_ready.
module inv_converter_pipe #(
    parameter int DATA_W = 8,
    parameter int LANES  = 1
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_W-1:0]       data_i,
    input  logic [1:0]                    mode_i,
    input  logic [LANES-1:0]              neg_i,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*(DATA_W+1)-1:0]   inv_o,
    output logic [LANES-1:0]              ovf_o
);
    localparam int RW = DATA_W + 1;
    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    logic                v1, v2;
    logic                ld1, ld2;
    logic [LANES*RW-1:0] s1_x, s1_x_d;
    logic [LANES-1:0]    s1_cin, s1_cin_d;
    logic [LANES-1:0]    s1_ovf, s1_ovf_d;
    logic [LANES*RW-1:0] s2_sum_d;

    assign ld2       = ~v2 | out_ready;
    assign ld1       = ~v1 | ld2;
    assign in_ready  = ld1;
    assign out_valid = v2;

    // S1: one's complement of the sign-extended operand; the +1 is deferred to S2.
    always_comb begin
        logic [DATA_W-1:0] op;
        logic              inv;
        logic [RW-1:0]     x_ext;
        s1_x_d   = '0;
        s1_cin_d = '0;
        s1_ovf_d = '0;
        op       = '0;
        inv      = 1'b0;
        x_ext    = '0;
        for (int k = 0; k < LANES; k++) begin
            op = data_i[k*DATA_W +: DATA_W];
            case (mode_i)
                2'b00:   inv = 1'b0;
                2'b01:   inv = 1'b1;
                2'b10:   inv = op[DATA_W-1];
                default: inv = neg_i[k];
            endcase
            x_ext                   = {op[DATA_W-1], op};
            s1_x_d[k*RW +: RW]      = x_ext ^ {RW{inv}};
            s1_cin_d[k]             = inv;
            s1_ovf_d[k]             = inv & (op == MIN_VAL);
        end
    end

    always_comb begin
        s2_sum_d = '0;
        for (int k = 0; k < LANES; k++) begin
            s2_sum_d[k*RW +: RW] = s1_x[k*RW +: RW] + {{DATA_W{1'b0}}, s1_cin[k]};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            v1     <= 1'b0;
            s1_x   <= '0;
            s1_cin <= '0;
            s1_ovf <= '0;
        end else if (ld1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_x   <= s1_x_d;
                s1_cin <= s1_cin_d;
                s1_ovf <= s1_ovf_d;
            end
        end
    end

    // S2 data only moves when S1 holds a real beat; bubbles just clear v2.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            v2    <= 1'b0;
            inv_o <= '0;
            ovf_o <= '0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                inv_o <= s2_sum_d;
                ovf_o <= s1_ovf;
            end
        end
    end

endmodule

// File: tb/tb_inv_converter_pipe.sv
// Bench for inv_converter_pipe: an 8-bit single-lane instance and a 16-bit two-lane instance.
module tb_inv_converter_pipe;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    logic sys_rst_n;

    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] data_i;
    logic [1:0] mode_i;
    logic [0:0] neg_i;
    logic [8:0] inv_o;
    logic [0:0] ovf_o;

    logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w;
    logic [31:0] data_w;
    logic [1:0]  mode_w;
    logic [1:0]  neg_w;
    logic [33:0] inv_w;
    logic [1:0]  ovf_w;

    int n_cmp = 0;
    int n_err = 0;
    logic [9:0]  exp_q[$];
    logic [35:0] exp_q_w[$];

    inv_converter_pipe #(.DATA_W(8), .LANES(1)) dut8 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_i(data_i), .mode_i(mode_i), .neg_i(neg_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .inv_o(inv_o), .ovf_o(ovf_o)
    );

    inv_converter_pipe #(.DATA_W(16), .LANES(2)) dut16 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .in_valid(in_valid_w), .in_ready(in_ready_w),
        .data_i(data_w), .mode_i(mode_w), .neg_i(neg_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w),
        .inv_o(inv_w), .ovf_o(ovf_w)
    );

    // Reference: exact integer arithmetic, then truncation to 9 bits.
    function automatic logic [9:0] model8(input logic [7:0] d, input logic [1:0] m, input logic n);
        int v, r;
        logic [8:0] rv;
        v = int'($signed(d));
        case (m)
            2'd0:    r = v;
            2'd1:    r = -v;
            2'd2:    r = (v < 0) ? -v : v;
            default: r = n ? -v : v;
        endcase
        rv = r[8:0];
        return {(r > 127 || r < -128), rv};
    endfunction

    // Observes one cycle of the 8-bit instance mid-cycle, then advances past the next rising edge.
    task automatic tick(output bit acc, output bit emit, output bit rdy,
                        output logic [8:0] o_inv, output logic o_ovf);
        @(negedge sys_clk);
        acc   = in_valid & in_ready;
        emit  = out_valid & out_ready;
        rdy   = in_ready;
        o_inv = inv_o;
        o_ovf = ovf_o[0];
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst_n   = 1'b0;
        out_ready   = 1'b1;
        out_ready_w = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid   = 1'b1;
            data_i     = 8'($urandom);
            mode_i     = 2'($urandom_range(3, 0));
            neg_i      = 1'($urandom_range(1, 0));
            in_valid_w = 1'b1;
            data_w     = $urandom;
            mode_w     = 2'($urandom_range(3, 0));
            neg_w      = 2'($urandom_range(3, 0));
            @(negedge sys_clk);
            n_cmp++;
            if (out_valid !== 1'b0 || inv_o !== 9'h000 || ovf_o !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold8: out_valid=%b inv_o=%h ovf_o=%b, required 0/000/0",
                         out_valid, inv_o, ovf_o);
            end
            n_cmp++;
            if (out_valid_w !== 1'b0 || inv_w !== 34'h0 || ovf_w !== 2'b00) begin
                n_err++;
                $display("FAIL reset_hold16: out_valid=%b inv_o=%h ovf_o=%b, required 0/0/00",
                         out_valid_w, inv_w, ovf_w);
            end
            @(posedge sys_clk);
            #1;
        end
        in_valid   = 1'b0;
        in_valid_w = 1'b0;
        sys_rst_n  = 1'b1;
        @(negedge sys_clk);
        n_cmp++;
        if (in_ready !== 1'b1 || in_ready_w !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: in_ready8=%b in_ready16=%b, required 1/1", in_ready, in_ready_w);
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_negate();
        logic [7:0] d_t[3] = '{8'h80, 8'h01, 8'h00};
        logic [8:0] e_t[3] = '{9'h080, 9'h1FF, 9'h000};
        logic       o_t[3] = '{1'b1, 1'b0, 1'b0};
        bit acc, emit, rdy;
        logic [8:0] gi;
        logic go;
        logic [9:0] ev;
        int lat;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            data_i    = d_t[i];
            mode_i    = 2'b01;
            neg_i     = 1'b0;
            out_ready = 1'b1;
            tick(acc, emit, rdy, gi, go);
            n_cmp++;
            if (!acc) begin
                n_err++;
                $display("FAIL neg_accept[%0d]: accepted=%b, required 1", i, acc);
            end
            exp_q.push_back({o_t[i], e_t[i]});
            in_valid = 1'b0;
            lat  = 0;
            emit = 1'b0;
            while (!emit && lat < 10) begin
                tick(acc, emit, rdy, gi, go);
                lat++;
            end
            n_cmp++;
            if (!emit || lat != 2) begin
                n_err++;
                $display("FAIL neg_latency[%0d]: emitted=%b after %0d cycles, required 2", i, emit, lat);
            end
            if (emit) begin
                ev = exp_q.pop_front();
                n_cmp++;
                if ({go, gi} !== ev) begin
                    n_err++;
                    $display("FAIL neg_data[%0d]: ovf=%b inv=%h, required ovf=%b inv=%h",
                             i, go, gi, ev[9], ev[8:0]);
                end
            end else begin
                exp_q.delete();
            end
        end
    endtask

    task automatic test_abs_pass();
        logic [7:0] d_t[3] = '{8'hF6, 8'h7F, 8'h9C};
        logic [1:0] m_t[3] = '{2'b10, 2'b10, 2'b00};
        logic [8:0] e_t[3] = '{9'h00A, 9'h07F, 9'h19C};
        bit acc, emit, rdy;
        logic [8:0] gi;
        logic go;
        logic [9:0] ev;
        int lat;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            data_i    = d_t[i];
            mode_i    = m_t[i];
            out_ready = 1'b1;
            tick(acc, emit, rdy, gi, go);
            if (acc) exp_q.push_back({1'b0, e_t[i]});
            in_valid = 1'b0;
            lat  = 0;
            emit = 1'b0;
            while (!emit && lat < 10) begin
                tick(acc, emit, rdy, gi, go);
                lat++;
            end
            n_cmp++;
            if (!emit || exp_q.size() == 0) begin
                n_err++;
                $display("FAIL abs_pass_timeout[%0d]: emitted=%b queued=%0d, required an output",
                         i, emit, exp_q.size());
                exp_q.delete();
            end else begin
                ev = exp_q.pop_front();
                if ({go, gi} !== ev) begin
                    n_err++;
                    $display("FAIL abs_pass_data[%0d]: ovf=%b inv=%h, required ovf=%b inv=%h",
                             i, go, gi, ev[9], ev[8:0]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] e_t[4] = '{9'h1FB, 9'h1FA, 9'h1F9, 9'h1F8};
        bit acc, emit, rdy;
        logic [8:0] gi;
        logic go;
        logic [9:0] ev;
        int b = 0;
        int n_out = 0;
        bit started = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (b < 4);
            data_i    = 8'(5 + b);
            mode_i    = 2'b01;
            tick(acc, emit, rdy, gi, go);
            if (acc) begin
                exp_q.push_back({1'b0, e_t[b]});
                b++;
            end
            if (cyc == 2) begin
                n_cmp++;
                if (rdy !== 1'b0 || b != 2) begin
                    n_err++;
                    $display("FAIL bp_in_ready: in_ready=%b beats_held=%0d, required 0 with 2", rdy, b);
                end
            end
            if (emit) begin
                started = 1'b1;
                n_out++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL bp_extra: inv=%h emitted, required no output", gi);
                end else begin
                    ev = exp_q.pop_front();
                    if ({go, gi} !== ev) begin
                        n_err++;
                        $display("FAIL bp_data: ovf=%b inv=%h, required ovf=%b inv=%h",
                                 go, gi, ev[9], ev[8:0]);
                    end
                end
            end else if (started && (exp_q.size() != 0 || b < 4)) begin
                n_cmp++;
                n_err++;
                $display("FAIL bp_gap: no output at cycle %0d, required back-to-back", cyc);
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (n_out != 4) begin
            n_err++;
            $display("FAIL bp_count: %0d outputs, required 4", n_out);
        end
        exp_q.delete();
    endtask

    task automatic test_lanes();
        logic [31:0] d_t[2] = '{{16'h8000, 16'h1234}, {16'hFFFF, 16'h8000}};
        logic [1:0]  n_t[2] = '{2'b10, 2'b01};
        logic [35:0] e_t[2] = '{{2'b10, 17'h08000, 17'h01234}, {2'b01, 17'h1FFFF, 17'h08000}};
        logic [35:0] ev;
        int lat;
        out_ready_w = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid_w = 1'b1;
            data_w     = d_t[i];
            mode_w     = 2'b11;
            neg_w      = n_t[i];
            @(negedge sys_clk);
            if (in_valid_w && in_ready_w) exp_q_w.push_back(e_t[i]);
            @(posedge sys_clk);
            #1;
            in_valid_w = 1'b0;
            lat = 0;
            @(negedge sys_clk);
            while (!out_valid_w && lat < 10) begin
                @(negedge sys_clk);
                lat++;
            end
            n_cmp++;
            if (!out_valid_w || exp_q_w.size() == 0) begin
                n_err++;
                $display("FAIL lanes_timeout[%0d]: out_valid=%b, required an output", i, out_valid_w);
                exp_q_w.delete();
            end else begin
                ev = exp_q_w.pop_front();
                if (inv_w[33:17] !== ev[33:17] || ovf_w[1] !== ev[35]) begin
                    n_err++;
                    $display("FAIL lanes_lane1[%0d]: inv=%h ovf=%b, required inv=%h ovf=%b",
                             i, inv_w[33:17], ovf_w[1], ev[33:17], ev[35]);
                end
                n_cmp++;
                if (inv_w[16:0] !== ev[16:0] || ovf_w[0] !== ev[34]) begin
                    n_err++;
                    $display("FAIL lanes_lane0[%0d]: inv=%h ovf=%b, required inv=%h ovf=%b",
                             i, inv_w[16:0], ovf_w[0], ev[16:0], ev[34]);
                end
            end
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic test_reset_midstream();
        bit acc, emit, rdy;
        logic [8:0] gi;
        logic go;
        logic [9:0] ev;
        int n_out = 0;
        out_ready = 1'b0;
        mode_i    = 2'b01;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            data_i   = 8'(8'h11 * (i + 1));
            tick(acc, emit, rdy, gi, go);
            if (acc) exp_q.push_back(model8(data_i, mode_i, 1'b0));
        end
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_prefill: out_valid=%b, required 1 before reset", out_valid);
        end
        #1 sys_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || inv_o !== 9'h000) begin
            n_err++;
            $display("FAIL mid_async_clear: out_valid=%b inv_o=%h, required 0/000", out_valid, inv_o);
        end
        exp_q.delete();
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_i    = 8'h33;
        mode_i    = 2'b00;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick(acc, emit, rdy, gi, go);
            if (acc) begin
                exp_q.push_back({1'b0, 9'h033});
                in_valid = 1'b0;
            end
            if (emit) begin
                n_out++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL mid_stale: inv=%h emitted, required no output", gi);
                end else begin
                    ev = exp_q.pop_front();
                    if ({go, gi} !== ev) begin
                        n_err++;
                        $display("FAIL mid_data: ovf=%b inv=%h, required ovf=%b inv=%h",
                                 go, gi, ev[9], ev[8:0]);
                    end
                end
            end
        end
        n_cmp++;
        if (n_out != 1) begin
            n_err++;
            $display("FAIL mid_count: %0d outputs after reset, required 1", n_out);
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        localparam int N = 32768;
        bit acc, emit, rdy;
        logic [8:0] gi;
        logic go;
        logic [9:0] ev;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        while (got < N && cyc < 60000) begin
            in_valid  = (sent < N) && ($urandom_range(15, 0) != 0);
            data_i    = 8'($urandom);
            mode_i    = 2'($urandom_range(3, 0));
            neg_i     = 1'($urandom_range(1, 0));
            out_ready = ($urandom_range(15, 0) != 0);
            tick(acc, emit, rdy, gi, go);
            if (acc) begin
                exp_q.push_back(model8(data_i, mode_i, neg_i[0]));
                sent++;
            end
            if (emit) begin
                got++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_extra: beat %0d inv=%h, required no output", got, gi);
                end else begin
                    ev = exp_q.pop_front();
                    if ({go, gi} !== ev) begin
                        n_err++;
                        $display("FAIL rand_data: beat %0d ovf=%b inv=%h, required ovf=%b inv=%h",
                                 got, go, gi, ev[9], ev[8:0]);
                    end
                end
            end
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got != N || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rand_complete: %0d outputs, %0d pending, required %0d and 0",
                     got, exp_q.size(), N);
        end
    endtask

    initial begin
        sys_rst_n   = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        data_i      = '0;
        mode_i      = '0;
        neg_i       = '0;
        in_valid_w  = 1'b0;
        out_ready_w = 1'b1;
        data_w      = '0;
        mode_w      = '0;
        neg_w       = '0;
        @(posedge sys_clk);
        #1;
        test_reset();
        test_negate();
        test_abs_pass();
        test_backpressure();
        test_lanes();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inv_converter_pipe.md
Name: inv_converter_pipe

Overview:
Parametrised, pipelined two's-complement sign-conversion block for the Booth-4/Wallace multiplier datapath. It takes LANES signed operands of DATA_W bits, one beat per transfer. For each lane it produces a sign-extended, negated or absolute result at DATA_W+1 bits, so the negated minimum value never overflows. It has valid/ready flow control on both sides and feeds partial-product generation, where the Booth "neg" bit selects the inversion per lane.

Parameters:
DATA_W, 8, operand width per lane in bits (>=2)
LANES, 1, number of independent lanes processed in parallel (>=1)

Ports:
sys_clk  in  1  system clock, all state updates on the rising edge
sys_rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept an input beat this cycle
data_i  in  LANES*DATA_W  signed operands; lane k occupies bits [k*DATA_W +: DATA_W]
mode_i  in  2  00 pass, 01 negate, 10 absolute value, 11 per-lane conditional negate
neg_i  in  LANES  per-lane negate request, used only when mode_i=11
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the output beat
inv_o  out  LANES*(DATA_W+1)  signed results; lane k occupies bits [k*(DATA_W+1) +: DATA_W+1]
ovf_o  out  LANES  per-lane flag: result does not fit in DATA_W signed bits

Behaviour:
- Reset (asynchronous, sys_rst_n=0): both stage valids clear; out_valid=0, inv_o=0, ovf_o=0; in_ready=1 in the first cycle after release.
- Transfer: input on in_valid & in_ready; output on out_valid & out_ready. mode_i and neg_i are sampled together with data_i.
- Per-lane invert decision, made at S1:
  - mode 00: 0
  - mode 01: 1
  - mode 10: equal to the operand sign bit
  - mode 11: neg_i[k]
- Stage S1 (register):
  - x_ext = sign-extension of the operand to DATA_W+1 bits.
  - Store x_ext XOR {DATA_W+1{inv}}, carry-in bit = inv, and ovf = inv & (operand == 1 followed by DATA_W-1 zeros).
- Stage S2 (register): inv_o lane = stored one's-complement + carry-in, modulo 2^(DATA_W+1); ovf_o lane registered alongside.
- Latency: exactly 2 cycles from input acceptance to out_valid when out_ready stays high. Throughput is 1 beat per cycle.
- Flow control:
  - S2 loads when it is empty or out_ready=1.
  - S1 loads when it is empty or S2 loads.
  - in_ready = ~v1 | ~v2 | out_ready (combinational; no combinational path from in_valid).
  - A stalled stage holds its data and flags unchanged. No beat is dropped, duplicated or reordered.
- Bubbles: if S1 is empty while S2 drains, S2 clears its valid. Data registers may retain stale values, but out_valid=0.
- Simultaneous accept and emit in the same cycle with a full pipe is legal and sustains full rate.
- Width rule: pass and abs of any value, and negate of MIN, are exact at DATA_W+1 bits. Negate of 0 gives 0 with ovf=0.
- Reset asserted mid-stream discards all in-flight beats immediately. No output appears for them after release.
- Lanes are fully independent; lane results share one valid/ready.

Test Plan:
1. Reset: hold sys_rst_n=0, toggle inputs -> out_valid=0, inv_o=0, ovf_o=0. After release, in_ready=1.
2. DATA_W=8, LANES=1, mode 01:
   - data 8'h80 -> inv_o=9'h080, ovf_o=1, out_valid exactly 2 cycles after acceptance.
   - data 8'h01 -> 9'h1FF, ovf=0.
   - data 8'h00 -> 9'h000.
3. Mode 10 / mode 00, DATA_W=8:
   - abs 8'hF6 -> 9'h00A; abs 8'h7F -> 9'h07F.
   - pass 8'h9C -> 9'h19C; ovf=0 throughout.
4. Backpressure: stream 4 beats (0x05, 0x06, 0x07, 0x08, mode 01) with out_ready=0 for 3 cycles:
   - in_ready drops after 2 beats are held.
   - On release, outputs are 9'h1FB, 1FA, 1F9, 1F8 in order, with no gaps once steady.
5. LANES=2, DATA_W=16, mode 11, neg_i=2'b10, data {16'h8000, 16'h1234}:
   - lane1 = 17'h08000 with ovf[1]=1.
   - lane0 = 17'h01234 with ovf[0]=0.
6. Reset mid-stream: assert sys_rst_n low with 2 beats in flight -> out_valid falls asynchronously. After release, only newly accepted beats emerge. Random 32768-beat comparison against the reference model matches.
